freq_sweep_ctrl: RTL and testbench
==================================

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 The module SHALL have parameter DWELL_CYCLES, default 1000000: sysclk cycles per sweep step, legal range 1..2^24.
REQ-002 The module SHALL have parameter SCALE_MIN, default 0: lowest legal Scale value.
REQ-003 The module SHALL have parameter SCALE_MAX, default 63: highest legal Scale value, with SCALE_MIN < SCALE_MAX <= 63.
REQ-004 The module SHALL have parameter STEP, default 1: Scale increment per sweep step, legal range 1..63.
REQ-005 The module SHALL have port sysclk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have ports Plus and Minus, input, 1 bit each: debounced, sysclk-synchronous button levels.
REQ-008 The module SHALL have port Start, input, 1 bit: debounced, synchronous level that starts, pauses and resumes the sweep.
REQ-009 The module SHALL have port Sweep_en, input, 1 bit: level; 0 selects manual mode, 1 permits sweep.
REQ-010 The module SHALL have port Scale, output, 6 bits: registered frequency-divider select driven to the Divider.
REQ-011 The module SHALL have port Busy, output, 1 bit: registered; high in SWEEP_UP or SWEEP_DOWN.
REQ-012 The module SHALL have port Dir, output, 1 bit: registered; 1 = sweep ascending, 0 = descending; held in PAUSE and MANUAL.

Function
REQ-013 Edge detect: each of Plus, Minus and Start SHALL have a previous-value register, and an event SHALL be input high while its previous-value register is low.
REQ-014 Latency: an event SHALL take effect at the same clock edge that first samples the input high.
REQ-015 The FSM SHALL have the states MANUAL, SWEEP_UP, SWEEP_DOWN and PAUSE.
REQ-016 In MANUAL, a Plus event SHALL increment Scale by 1, saturating at SCALE_MAX.
REQ-017 In MANUAL, a Minus event SHALL decrement Scale by 1, saturating at SCALE_MIN.
REQ-018 In MANUAL, simultaneous Plus and Minus events SHALL leave Scale unchanged.
REQ-019 In MANUAL with Sweep_en=1, a Start event SHALL go to SWEEP_UP with Dir=1 if Scale < SCALE_MAX, else to SWEEP_DOWN with Dir=0, and SHALL load the dwell counter with DWELL_CYCLES-1.
REQ-020 In MANUAL with Sweep_en=0, a Start event SHALL be ignored.
REQ-021 In SWEEP_UP and SWEEP_DOWN, the dwell counter SHALL decrement once per cycle.
REQ-022 In SWEEP_UP and SWEEP_DOWN, when the dwell counter is 0, Scale SHALL step by STEP in the current direction and the counter SHALL reload with DWELL_CYCLES-1, giving exactly one step every DWELL_CYCLES cycles.
REQ-023 Arithmetic SHALL use at least 7 bits, and a step crossing a limit SHALL clamp Scale to that limit, with no overshoot and no wrap.
REQ-024 In SWEEP_UP, a step that makes Scale equal to SCALE_MAX SHALL transition to SWEEP_DOWN with Dir=0 at the same edge.
REQ-025 In SWEEP_DOWN, a step that makes Scale equal to SCALE_MIN SHALL transition to SWEEP_UP with Dir=1 at the same edge.
REQ-026 Plus and Minus events SHALL be ignored in SWEEP_UP, SWEEP_DOWN and PAUSE.
REQ-027 A Start event in SWEEP_UP or SWEEP_DOWN SHALL go to PAUSE, freezing Scale, the dwell counter and Dir.
REQ-028 A Start event in PAUSE SHALL return to SWEEP_UP if Dir=1, else to SWEEP_DOWN, and SHALL resume the frozen counter value without reloading it.
REQ-029 Sweep_en=0 in SWEEP_UP, SWEEP_DOWN or PAUSE SHALL force MANUAL at the next edge, keeping Scale, with priority over a Start event and over a step in the same cycle.
REQ-030 Busy SHALL equal 1 exactly when the registered state is SWEEP_UP or SWEEP_DOWN.
REQ-031 Scale SHALL never leave [SCALE_MIN, SCALE_MAX] in any state.

Reset
REQ-032 reset low SHALL asynchronously force: state MANUAL, Scale=SCALE_MIN, Dir=1, Busy=0, dwell counter=0, and all previous-value registers=0.
REQ-033 Release of reset SHALL be sampled synchronously, and an input held high through reset release SHALL produce exactly one event on the first active edge.
REQ-034 Reset asserted mid-sweep or mid-pause SHALL abort immediately to the REQ-032 values, with no further step.

Verification (bench parameters DWELL_CYCLES=4, SCALE_MIN=0, SCALE_MAX=63, STEP=1 unless stated)
REQ-035 Manual saturation: from reset, 3 Minus pulses, then 70 Plus pulses -> Scale stays 0, then increments 1 per pulse and holds at 63; Plus and Minus asserted in the same cycle -> Scale unchanged.
REQ-036 Sweep timing: Scale=60, Sweep_en=1, Start pulse -> Busy=1, Dir=1; Scale reaches 61, 62, 63 at 4-cycle intervals; Dir=0 at the edge Scale=63; the next step gives 62.
REQ-037 Clamp: STEP=5, SCALE_MAX=63, sweep from 60 -> next value is 63, not 65 and not a wrapped value, with Dir flipping to 0.
REQ-038 Pause/resume: Start pulse 2 cycles into a dwell -> PAUSE, Busy=0; hold 20 cycles -> Scale frozen; Start pulse -> next step occurs 2 cycles after resume.
REQ-039 Abort paths: Sweep_en dropped on the same cycle as a dwell step -> MANUAL next edge, Scale not stepped; asynchronous reset mid-sweep -> Scale=0, Busy=0 without a clock edge.
REQ-040 Reset edge case: Plus held high across reset release -> exactly one increment (Scale=1); the button held for a further 50 cycles produces no further change.

Source files
------------

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller: manual Plus/Minus adjustment of the divider Scale,
// plus an automatic triangle sweep between SCALE_MIN and SCALE_MAX with pause/resume.
module freq_sweep_ctrl #(
    parameter int DWELL_CYCLES = 1000000,
    parameter int SCALE_MIN    = 0,
    parameter int SCALE_MAX    = 63,
    parameter int STEP         = 1
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       Plus,
    input  logic       Minus,
    input  logic       Start,
    input  logic       Sweep_en,
    output logic [5:0] Scale,
    output logic       Busy,
    output logic       Dir
);

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2,
        PAUSE      = 2'd3
    } state_e;

    localparam int              CNT_W  = 24;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [5:0]      MAX6   = 6'(SCALE_MAX);
    localparam logic [5:0]      MIN6   = 6'(SCALE_MIN);
    localparam logic [5:0]      STEP6  = 6'(STEP);
    localparam logic [7:0]      MAX8   = 8'(SCALE_MAX);
    localparam logic [7:0]      LOW8   = 8'(SCALE_MIN + STEP);

    state_e           state_q, state_d;
    logic [5:0]       scale_q, scale_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             plus_prev_q, minus_prev_q, start_prev_q;

    logic       plus_ev, minus_ev, start_ev;
    logic       sweep_start, dwell_done;
    logic [7:0] up_sum;
    logic       up_hit, down_hit;

    assign plus_ev     = Plus  & ~plus_prev_q;
    assign minus_ev    = Minus & ~minus_prev_q;
    assign start_ev    = Start & ~start_prev_q;
    assign sweep_start = start_ev & Sweep_en;
    assign dwell_done  = (cnt_q == '0);

    // 8-bit arithmetic so a step past either limit is detected before it can wrap.
    assign up_sum   = {2'b00, scale_q} + 8'(STEP6);
    assign up_hit   = (up_sum >= MAX8);
    assign down_hit = ({2'b00, scale_q} <= LOW8);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= MANUAL;
            scale_q      <= MIN6;
            cnt_q        <= '0;
            dir_q        <= 1'b1;
            busy_q       <= 1'b0;
            plus_prev_q  <= 1'b0;
            minus_prev_q <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scale_q      <= scale_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            plus_prev_q  <= Plus;
            minus_prev_q <= Minus;
            start_prev_q <= Start;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MANUAL: begin
                if (sweep_start)
                    state_d = (scale_q < MAX6) ? SWEEP_UP : SWEEP_DOWN;
            end
            SWEEP_UP: begin
                if (!Sweep_en)                 state_d = MANUAL;
                else if (start_ev)             state_d = PAUSE;
                else if (dwell_done && up_hit) state_d = SWEEP_DOWN;
            end
            SWEEP_DOWN: begin
                if (!Sweep_en)                   state_d = MANUAL;
                else if (start_ev)               state_d = PAUSE;
                else if (dwell_done && down_hit) state_d = SWEEP_UP;
            end
            PAUSE: begin
                if (!Sweep_en)     state_d = MANUAL;
                else if (start_ev) state_d = dir_q ? SWEEP_UP : SWEEP_DOWN;
            end
            default: state_d = MANUAL;
        endcase
    end

    always_comb begin
        scale_d = scale_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MANUAL: begin
                if (sweep_start)
                    cnt_d = RELOAD;
                else if (plus_ev && !minus_ev && (scale_q < MAX6))
                    scale_d = scale_q + 6'd1;
                else if (minus_ev && !plus_ev && (scale_q > MIN6))
                    scale_d = scale_q - 6'd1;
            end
            SWEEP_UP, SWEEP_DOWN: begin
                // Dropping Sweep_en or pausing freezes the dwell, so no step either.
                if (Sweep_en && !start_ev) begin
                    if (dwell_done) begin
                        cnt_d = RELOAD;
                        if (state_q == SWEEP_UP)
                            scale_d = up_hit ? MAX6 : up_sum[5:0];
                        else
                            scale_d = down_hit ? MIN6 : (scale_q - STEP6);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (state_d == SWEEP_UP)        dir_d = 1'b1;
        else if (state_d == SWEEP_DOWN) dir_d = 1'b0;
        else                            dir_d = dir_q;

        busy_d = (state_d == SWEEP_UP) || (state_d == SWEEP_DOWN);
    end

    assign Scale = scale_q;
    assign Busy  = busy_q;
    assign Dir   = dir_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed self-checking bench for freq_sweep_ctrl: a STEP=1 instance carries
// most checks, a STEP=5 instance sharing the same stimulus covers the clamp.
module tb_freq_sweep_ctrl;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       Plus, Minus, Start, Sweep_en;
    logic [5:0] scale,  scale5;
    logic       busy,   busy5;
    logic       dir,    dir5;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    freq_sweep_ctrl #(
        .DWELL_CYCLES(4), .SCALE_MIN(0), .SCALE_MAX(63), .STEP(1)
    ) dut (
        .sysclk(sysclk), .reset(reset), .Plus(Plus), .Minus(Minus),
        .Start(Start), .Sweep_en(Sweep_en),
        .Scale(scale), .Busy(busy), .Dir(dir)
    );

    freq_sweep_ctrl #(
        .DWELL_CYCLES(4), .SCALE_MIN(0), .SCALE_MAX(63), .STEP(5)
    ) dut_step5 (
        .sysclk(sysclk), .reset(reset), .Plus(Plus), .Minus(Minus),
        .Start(Start), .Sweep_en(Sweep_en),
        .Scale(scale5), .Busy(busy5), .Dir(dir5)
    );

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_plus();
        Plus = 1'b1; tick(); Plus = 1'b0; tick();
    endtask

    task automatic pulse_minus();
        Minus = 1'b1; tick(); Minus = 1'b0; tick();
    endtask

    initial begin
        reset = 1'b0; Plus = 1'b0; Minus = 1'b0; Start = 1'b0; Sweep_en = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        check("rst_scale", 32'(scale), 0);
        check("rst_busy",  32'(busy),  0);
        check("rst_dir",   32'(dir),   1);
        reset = 1'b1;
        tick();

        // Manual saturation at both ends
        for (int i = 0; i < 3; i++) begin
            pulse_minus();
            check("minus_sat_min", 32'(scale), 0);
        end
        for (int i = 0; i < 70; i++) begin
            pulse_plus();
            check("plus_count", 32'(scale), (i + 1 > 63) ? 63 : i + 1);
        end
        pulse_minus();
        check("minus_from_max", 32'(scale), 62);
        Plus = 1'b1; Minus = 1'b1; tick(); Plus = 1'b0; Minus = 1'b0; tick();
        check("plus_minus_same", 32'(scale), 62);

        // Start ignored while Sweep_en=0
        Start = 1'b1; tick(); Start = 1'b0;
        check("start_no_en_busy", 32'(busy), 0);
        tick();
        pulse_plus();
        check("still_manual", 32'(scale), 63);
        repeat (3) pulse_minus();
        check("preset_60", 32'(scale), 60);

        // Sweep timing from 60, one step every 4 cycles
        Sweep_en = 1'b1; tick();
        Start = 1'b1; tick(); Start = 1'b0;
        check("sweep_busy", 32'(busy), 1);
        check("sweep_dir",  32'(dir),  1);
        check("sweep_hold", 32'(scale), 60);
        check("s5_busy",    32'(busy5), 1);
        repeat (3) tick();
        check("dwell_hold", 32'(scale), 60);
        tick();
        check("step_61", 32'(scale), 61);
        check("s5_clamp_63", 32'(scale5), 63);
        check("s5_dir_flip", 32'(dir5), 0);
        repeat (4) tick();
        check("step_62", 32'(scale), 62);
        check("dir_up_62", 32'(dir), 1);
        repeat (4) tick();
        check("step_63", 32'(scale), 63);
        check("dir_flip_63", 32'(dir), 0);
        check("busy_at_63", 32'(busy), 1);
        repeat (4) tick();
        check("step_down_62", 32'(scale), 62);

        // Pause two cycles into a dwell, then resume with the frozen count
        repeat (2) tick();
        Start = 1'b1; tick(); Start = 1'b0;
        check("pause_busy", 32'(busy), 0);
        repeat (20) tick();
        check("pause_scale", 32'(scale), 62);
        check("pause_dir",   32'(dir),   0);
        Start = 1'b1; tick(); Start = 1'b0;
        check("resume_busy",  32'(busy),  1);
        check("resume_scale", 32'(scale), 62);
        tick();
        check("resume_wait", 32'(scale), 62);
        tick();
        check("resume_step_61", 32'(scale), 61);

        // Sweep_en dropped on the step cycle
        repeat (3) tick();
        Sweep_en = 1'b0; tick();
        check("abort_busy",  32'(busy),  0);
        check("abort_scale", 32'(scale), 61);
        tick();
        check("abort_manual_hold", 32'(scale), 61);

        // Asynchronous reset mid-sweep
        Sweep_en = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        check("resweep_dir", 32'(dir), 1);
        repeat (5) tick();
        check("resweep_62", 32'(scale), 62);
        #1 reset = 1'b0;
        #1;
        check("async_scale", 32'(scale), 0);
        check("async_busy",  32'(busy),  0);
        check("async_dir",   32'(dir),   1);

        // Plus held across reset release gives exactly one increment
        Sweep_en = 1'b0;
        Plus = 1'b1;
        @(negedge sysclk);
        reset = 1'b1;
        tick();
        check("held_plus_once", 32'(scale), 1);
        repeat (50) tick();
        check("held_plus_hold", 32'(scale), 1);
        check("held_plus_busy", 32'(busy),  0);
        Plus = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
